// File: rtl/sum_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NUM_REQ requesters.
// Build option SUM_ARB_SAT_EN: saturate the result to W bits instead of keeping the carry.
//
// state  | meaning
// IDLE   | waiting for any req; arbitration happens on the sampling edge
// ADD    | winner's operands latched, gnt pulse visible, sum registered at the edge
// RESULT | tagged sum held under res_valid until res_ready
module sum_arbiter #(
  parameter int W       = 4,
  parameter int NUM_REQ = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] op_a,
  input  logic [NUM_REQ*W-1:0] op_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W:0]           res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ADD, RESULT} state_t;

  localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       win_q, win_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d;
  logic [NUM_REQ-1:0]   gnt_d;
  logic                 valid_d;
  logic [W:0]           data_d;
  logic [IDW-1:0]       id_d;
  logic                 busy_d;

  logic [IDW-1:0]       pick;
  logic                 pick_ok;
  logic [31:0]          scan;
  logic [IDW-1:0]       scan_idx;
  logic [W:0]           sum_raw;
  logic [W:0]           sum;

  // Scan starts one past the last winner so it always ends up lowest priority.
  always_comb begin
    pick     = '0;
    pick_ok  = 1'b0;
    scan     = '0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = 32'(ptr_q) + 32'(k);
      if (scan >= 32'(NUM_REQ)) scan = scan - 32'(NUM_REQ);
      scan_idx = scan[IDW-1:0];
      if (!pick_ok && req[scan_idx]) begin
        pick    = scan_idx;
        pick_ok = 1'b1;
      end
    end
  end

  assign sum_raw = {1'b0, a_q} + {1'b0, b_q};

`ifdef SUM_ARB_SAT_EN
  assign sum = sum_raw[W] ? {1'b0, {W{1'b1}}} : sum_raw;
`else
  assign sum = sum_raw;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    valid_d = res_valid;
    data_d  = res_data;
    id_d    = res_id;
    case (state_q)
      IDLE: begin
        if (pick_ok) begin
          gnt_d[pick] = 1'b1;
          a_d         = op_a[pick*W +: W];
          b_d         = op_b[pick*W +: W];
          win_d       = pick;
          ptr_d       = pick;
          state_d     = ADD;
        end
      end
      ADD: begin
        data_d  = sum;
        id_d    = win_q;
        valid_d = 1'b1;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_valid && res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      win_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      a_q       <= a_d;
      b_q       <= b_d;
      gnt       <= gnt_d;
      res_valid <= valid_d;
      res_data  <= data_d;
      res_id    <= id_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_sum_arbiter.sv
// Self-checking bench for sum_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin/sum model.
module tb_sum_arbiter;
  localparam int W   = 4;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   op_a, op_b;
  logic [N-1:0]     gnt;
  logic             res_valid, res_ready;
  logic [W:0]       res_data;
  logic [IDW-1:0]   res_id;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;
  int mptr;

  sum_arbiter #(.W(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int model_sum(input int a, input int b);
    int s;
    s = a + b;
`ifdef SUM_ARB_SAT_EN
    if (s > (1 << W) - 1) s = (1 << W) - 1;
`endif
    return s;
  endfunction

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
    rst = 1'b0;
    mptr = N - 1;
  endtask

  // One complete transaction: request, grant, result, optional backpressure, handshake.
  task automatic do_txn(input logic [N-1:0] r, input logic [N*W-1:0] av, input logic [N*W-1:0] bv,
                        input bit hold, input int bp);
    int w, exp_sum;
    logic [N-1:0] exp_gnt;
    w = rr_pick(mptr, r);
    exp_gnt = '0;
    exp_gnt[w] = 1'b1;
    exp_sum = model_sum(int'(av[w*W +: W]), int'(bv[w*W +: W]));
    req = r; op_a = av; op_b = bv;
    res_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    vectors++;
    if (gnt !== exp_gnt || busy !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL grant: gnt=%b busy=%b valid=%b, want gnt=%b busy=1 valid=0", gnt, busy, res_valid, exp_gnt);
    end
    if (!hold) req = '0;
    op_a = 16'($urandom); op_b = 16'($urandom);
    res_ready = (bp == 0);
    @(posedge clk); #1;
    vectors++;
    if (res_valid !== 1'b1 || res_data !== 5'(exp_sum) || res_id !== 2'(w) || gnt !== '0) begin
      miscompares++;
      $display("FAIL result: valid=%b data=%0d id=%0d gnt=%b, want valid=1 data=%0d id=%0d gnt=0",
               res_valid, res_data, res_id, gnt, exp_sum, w);
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (res_valid !== 1'b1 || res_data !== 5'(exp_sum) || res_id !== 2'(w) || gnt !== '0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold: valid=%b data=%0d id=%0d gnt=%b busy=%b, want valid=1 data=%0d id=%0d gnt=0 busy=1",
                 res_valid, res_data, res_id, gnt, busy, exp_sum, w);
      end
      if (i == bp - 1) res_ready = 1'b1;
    end
    @(posedge clk); #1;
    vectors++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL handshake: valid=%b busy=%b gnt=%b, want 0 0 0", res_valid, busy, gnt);
    end
    res_ready = 1'b0;
    mptr = w;
  endtask

  task automatic test_reset();
    req = 4'b1111; op_a = 16'($urandom); op_b = 16'($urandom); res_ready = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (gnt !== '0 || res_valid !== 1'b0 || res_data !== '0 || res_id !== '0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset: gnt=%b valid=%b data=%0d id=%0d busy=%b, want all 0", gnt, res_valid, res_data, res_id, busy);
      end
    end
    req = '0; res_ready = 1'b0;
    rst = 1'b0;
    mptr = N - 1;
  endtask

  task automatic test_idle();
    req = '0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (gnt !== '0 || busy !== 1'b0 || res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle: gnt=%b busy=%b valid=%b, want 0 0 0", gnt, busy, res_valid);
      end
    end
  endtask

  task automatic test_single();
    do_txn(4'b0001, 16'h0003, 16'h0004, 1'b0, 0);
  endtask

  task automatic test_round_robin();
    apply_reset(1);
    for (int i = 0; i < 5; i++) do_txn(4'b1111, 16'($urandom), 16'($urandom), 1'b1, 0);
    req = '0;
  endtask

  task automatic test_backpressure();
    do_txn(4'b0100, 16'($urandom), 16'($urandom), 1'b0, 5);
  endtask

  task automatic test_overflow();
    do_txn(4'b1000, 16'hFFFF, 16'hFFFF, 1'b0, 0);
    do_txn(4'b0010, 16'h00F0, 16'h0010, 1'b0, 1);
  endtask

  task automatic test_reset_mid(input bit in_result);
    req = 4'b1111; op_a = 16'($urandom); op_b = 16'($urandom); res_ready = 1'b0;
    @(posedge clk); #1;
    req = '0;
    if (in_result) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mptr = N - 1;
    vectors++;
    if (res_valid !== 1'b0 || gnt !== '0 || busy !== 1'b0 || res_data !== '0 || res_id !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b gnt=%b busy=%b data=%0d id=%0d, want all 0", res_valid, gnt, busy, res_data, res_id);
    end
    res_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_no_result: valid=%b, want 0", res_valid);
      end
    end
    do_txn(4'b1111, 16'($urandom), 16'($urandom), 1'b0, 0);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    for (int n = 0; n < 40; n++) begin
      r = 4'($urandom_range(0, 15));
      if (r == '0) begin
        req = '0;
        @(posedge clk); #1;
        vectors++;
        if (gnt !== '0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL random_idle: gnt=%b busy=%b, want 0 0", gnt, busy);
        end
      end else begin
        do_txn(r, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; res_ready = 1'b0;
    mptr = N - 1;
    test_reset();
    test_idle();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
